// File: rtl/sqrt_issue_ctrl_if.sv
// sqrt_issue_ctrl_if: operand, SquareRootModule and result channels of the sqrt issue controller
interface sqrt_issue_ctrl_if #(
    parameter int LAMP_FLOAT_E_DW = 8,
    parameter int LAMP_FLOAT_F_DW = 7
);
    localparam int W = 1 + LAMP_FLOAT_E_DW + LAMP_FLOAT_F_DW;
    localparam int F = LAMP_FLOAT_F_DW;
    logic         op_valid_i;
    logic         op_ready_o;
    logic [W-1:0] op_i;
    logic         invSqrt_i;
    logic         doSqrt_o;
    logic [F:0]   s_o;
    logic         is_exp_odd_o;
    logic         invSqrt_o;
    logic         valid_i;
    logic [2*F+1:0] res_i;
    logic         res_valid_o;
    logic         res_ready_i;
    logic [W-1:0] res_o;
    modport slave (
        input  op_valid_i, op_i, invSqrt_i, valid_i, res_i, res_ready_i,
        output op_ready_o, doSqrt_o, s_o, is_exp_odd_o, invSqrt_o, res_valid_o, res_o
    );
    modport master (
        output op_valid_i, op_i, invSqrt_i, valid_i, res_i, res_ready_i,
        input  op_ready_o, doSqrt_o, s_o, is_exp_odd_o, invSqrt_o, res_valid_o, res_o
    );
endinterface

// File: rtl/sqrt_issue_ctrl.sv
// sqrt_issue_ctrl: issues LAMP float (inv)sqrt operations to SquareRootModule and packs the rounded result
module sqrt_issue_ctrl #(
    parameter int LAMP_FLOAT_E_DW   = 8,
    parameter int LAMP_FLOAT_F_DW   = 7,
    parameter int LAMP_FLOAT_E_BIAS = 127
) (
    input logic clk,
    input logic rst,
    sqrt_issue_ctrl_if.slave bus
);
    localparam int E = LAMP_FLOAT_E_DW;
    localparam int F = LAMP_FLOAT_F_DW;
    localparam int W = 1 + E + F;
    localparam int R = 2 * (1 + F);
    localparam logic [E-1:0] BIAS    = E'(LAMP_FLOAT_E_BIAS);
    localparam logic [W-1:0] QNAN    = {1'b0, {E{1'b1}}, 1'b1, {(F-1){1'b0}}};
    localparam logic [W-1:0] POS_INF = {1'b0, {E{1'b1}}, {F{1'b0}}};

    typedef enum logic [1:0] {IDLE, WAIT, NORM, OUT} state_t;

    state_t         state_q, state_d;
    logic [F:0]     s_q, s_d;
    logic           odd_q, odd_d;
    logic           inv_q, inv_d;
    logic [E-1:0]   ebase_q, ebase_d;
    logic [R-1:0]   root_q, root_d;
    logic [W-1:0]   res_q, res_d;

    logic           sgn, zero, exp_max, nan, inf, special;
    logic [E-1:0]   ex, exp_unb, eb, exp_n;
    logic [F-1:0]   fr, mant;
    logic [F:0]     mant_r;
    logic           hi, guard, sticky;
    logic [W-1:0]   spec_res, norm_res;

    // Operand classification, special-case result and root normalization/RNE rounding
    always_comb begin
        sgn      = bus.op_i[W-1];
        ex       = bus.op_i[W-2:F];
        fr       = bus.op_i[F-1:0];
        zero     = ~|ex;
        exp_max  = &ex;
        nan      = exp_max & |fr;
        inf      = exp_max & ~|fr;
        special  = nan | zero | inf | sgn;
        spec_res = (nan | (sgn & ~zero)) ? QNAN :
                   zero ? (bus.invSqrt_i ? {sgn, {E{1'b1}}, {F{1'b0}}} : {sgn, {(E+F){1'b0}}}) :
                   (bus.invSqrt_i ? '0 : POS_INF);
        exp_unb  = ex - BIAS;
        eb       = E'($signed(exp_unb) >>> 1);
        hi       = root_q[R-1];
        mant     = hi ? root_q[2*F:F+1] : root_q[2*F-1:F];
        guard    = hi ? root_q[F] : root_q[F-1];
        sticky   = hi ? |root_q[F-1:0] : |root_q[F-2:0];
        mant_r   = {1'b0, mant} + {{F{1'b0}}, guard & (sticky | mant[0])};
        exp_n    = ebase_q + BIAS - {{(E-1){1'b0}}, ~hi} + {{(E-1){1'b0}}, mant_r[F]};
        norm_res = {1'b0, exp_n, mant_r[F-1:0]};
    end

    // Next-state and register-load decode for the single in-flight operation
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        odd_d   = odd_q;
        inv_d   = inv_q;
        ebase_d = ebase_q;
        root_d  = root_q;
        res_d   = res_q;
        case (state_q)
            IDLE: if (bus.op_valid_i) begin
                if (special) begin
                    res_d   = spec_res;
                    state_d = OUT;
                end else begin
                    s_d     = {1'b1, fr};
                    odd_d   = exp_unb[0];
                    inv_d   = bus.invSqrt_i;
                    ebase_d = bus.invSqrt_i ? -eb : eb;
                    state_d = WAIT;
                end
            end
            WAIT: if (bus.valid_i) begin
                root_d  = bus.res_i;
                state_d = NORM;
            end
            NORM: begin
                res_d   = norm_res;
                state_d = OUT;
            end
            OUT: if (bus.res_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            odd_q   <= 1'b0;
            inv_q   <= 1'b0;
            ebase_q <= '0;
            root_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            odd_q   <= odd_d;
            inv_q   <= inv_d;
            ebase_q <= ebase_d;
            root_q  <= root_d;
            res_q   <= res_d;
        end
    end

    assign bus.op_ready_o   = state_q == IDLE;
    assign bus.doSqrt_o     = state_q == WAIT;
    assign bus.s_o          = s_q;
    assign bus.is_exp_odd_o = odd_q;
    assign bus.invSqrt_o    = inv_q;
    assign bus.res_valid_o  = state_q == OUT;
    assign bus.res_o        = res_q;
endmodule

// File: tb/tb_sqrt_issue_ctrl.sv
// tb_sqrt_issue_ctrl: scoreboard bench for the sqrt issue controller with a directed SquareRootModule model
module tb_sqrt_issue_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errs = 0;
    int   done_cnt = 0;
    logic [9:0]  iss_q[$];
    logic [15:0] res_exp_q[$];
    logic [9:0]  iss_cur = '0;
    logic        dprev = 1'b0;

    sqrt_issue_ctrl_if #(.LAMP_FLOAT_E_DW(8), .LAMP_FLOAT_F_DW(7)) bus ();

    sqrt_issue_ctrl #(
        .LAMP_FLOAT_E_DW(8), .LAMP_FLOAT_F_DW(7), .LAMP_FLOAT_E_BIAS(127)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares issue signals and results against the scoreboard queues
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                dprev = 1'b0;
            end else begin
                if (bus.doSqrt_o && !dprev) begin
                    if (iss_q.size() == 0) begin
                        checks++; errs++;
                        $display("FAIL unexpected_issue: got doSqrt_o=1 expected no request");
                    end else begin
                        iss_cur = iss_q.pop_front();
                        chk("issue", {22'd0, bus.s_o, bus.is_exp_odd_o, bus.invSqrt_o}, {22'd0, iss_cur});
                    end
                end else if (bus.doSqrt_o) begin
                    chk("issue_hold", {22'd0, bus.s_o, bus.is_exp_odd_o, bus.invSqrt_o}, {22'd0, iss_cur});
                end
                dprev = bus.doSqrt_o;
                if (bus.res_valid_o && bus.res_ready_i) begin
                    if (res_exp_q.size() == 0) begin
                        checks++; errs++;
                        $display("FAIL unexpected_result: got res_o=%h expected none", bus.res_o);
                    end else begin
                        chk("result", {16'd0, bus.res_o}, {16'd0, res_exp_q.pop_front()});
                    end
                    done_cnt++;
                end
            end
        end
    end

    task automatic run_op(input logic [15:0] op, input logic inv, input logic special,
                          input logic [15:0] root, input int lat, input logic [9:0] exp_iss,
                          input logic [15:0] exp_res, input logic hold);
        int d0;
        int n;
        d0 = done_cnt;
        res_exp_q.push_back(exp_res);
        if (!special) iss_q.push_back(exp_iss);
        bus.res_ready_i = !hold;
        chk("op_ready_idle", {31'd0, bus.op_ready_o}, 32'd1);
        bus.op_valid_i = 1'b1;
        bus.op_i = op;
        bus.invSqrt_i = inv;
        step();
        bus.op_valid_i = 1'b0;
        if (special) begin
            chk("special_no_dosqrt", {31'd0, bus.doSqrt_o}, 32'd0);
        end else begin
            chk("dosqrt_first_cycle", {31'd0, bus.doSqrt_o}, 32'd1);
            chk("op_ready_busy", {31'd0, bus.op_ready_o}, 32'd0);
            repeat (lat) step();
            bus.valid_i = 1'b1;
            bus.res_i = root;
            step();
            bus.valid_i = 1'b0;
            chk("norm_dosqrt_low", {31'd0, bus.doSqrt_o}, 32'd0);
            chk("norm_no_valid", {31'd0, bus.res_valid_o}, 32'd0);
            step();
        end
        chk("res_valid_latency", {31'd0, bus.res_valid_o}, 32'd1);
        if (hold) begin
            repeat (4) begin
                step();
                chk("hold_valid", {31'd0, bus.res_valid_o}, 32'd1);
                chk("hold_op_ready", {31'd0, bus.op_ready_o}, 32'd0);
                chk("hold_res", {16'd0, bus.res_o}, {16'd0, exp_res});
            end
            bus.res_ready_i = 1'b1;
        end
        n = 0;
        while (done_cnt == d0 && n < 20) begin
            step();
            n++;
        end
        if (done_cnt == d0) begin
            checks++; errs++;
            $display("FAIL result_timeout: got no result expected %h", exp_res);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.op_valid_i = 1'b0;
        bus.op_i = '0;
        bus.invSqrt_i = 1'b0;
        bus.valid_i = 1'b0;
        bus.res_i = '0;
        bus.res_ready_i = 1'b1;
        repeat (3) step();
        chk("rst_op_ready", {31'd0, bus.op_ready_o}, 32'd1);
        chk("rst_dosqrt", {31'd0, bus.doSqrt_o}, 32'd0);
        chk("rst_s", {24'd0, bus.s_o}, 32'd0);
        chk("rst_odd_inv", {30'd0, bus.is_exp_odd_o, bus.invSqrt_o}, 32'd0);
        chk("rst_res_valid", {31'd0, bus.res_valid_o}, 32'd0);
        chk("rst_res", {16'd0, bus.res_o}, 32'd0);
        rst = 1'b1;
        step();
        // op, inv, special, root, lat, {s,odd,inv}, expected result, hold
        run_op(16'h4080, 1'b0, 1'b0, 16'h8000, 5, {8'h80, 1'b0, 1'b0}, 16'h4000, 1'b0);
        run_op(16'h4080, 1'b1, 1'b0, 16'h8000, 2, {8'h80, 1'b0, 1'b1}, 16'h3F00, 1'b0);
        run_op(16'h4000, 1'b1, 1'b0, 16'h5A82, 3, {8'h80, 1'b1, 1'b1}, 16'h3F35, 1'b0);
        run_op(16'h4000, 1'b0, 1'b0, 16'hB505, 1, {8'h80, 1'b1, 1'b0}, 16'h3FB5, 1'b1);
        run_op(16'h4080, 1'b0, 1'b0, 16'h8080, 0, {8'h80, 1'b0, 1'b0}, 16'h4000, 1'b0);
        run_op(16'h4080, 1'b0, 1'b0, 16'h8180, 1, {8'h80, 1'b0, 1'b0}, 16'h4002, 1'b0);
        run_op(16'h4080, 1'b0, 1'b0, 16'hFF80, 1, {8'h80, 1'b0, 1'b0}, 16'h4080, 1'b0);
        run_op(16'hBF80, 1'b0, 1'b1, 16'h0000, 0, 10'd0, 16'h7FC0, 1'b0);
        run_op(16'h0000, 1'b1, 1'b1, 16'h0000, 0, 10'd0, 16'h7F80, 1'b0);
        run_op(16'h8000, 1'b0, 1'b1, 16'h0000, 0, 10'd0, 16'h8000, 1'b0);
        run_op(16'h7F80, 1'b1, 1'b1, 16'h0000, 0, 10'd0, 16'h0000, 1'b0);
        run_op(16'h8000, 1'b1, 1'b1, 16'h0000, 0, 10'd0, 16'hFF80, 1'b0);
        run_op(16'h7FC1, 1'b1, 1'b1, 16'h0000, 0, 10'd0, 16'h7FC0, 1'b0);
        run_op(16'h0001, 1'b0, 1'b1, 16'h0000, 0, 10'd0, 16'h0000, 1'b0);
        run_op(16'h7F80, 1'b0, 1'b1, 16'h0000, 0, 10'd0, 16'h7F80, 1'b1);
        // Reset while a request is outstanding: outputs clear at once, no result follows
        iss_q.push_back({8'h80, 1'b0, 1'b0});
        bus.op_valid_i = 1'b1;
        bus.op_i = 16'h4080;
        bus.invSqrt_i = 1'b0;
        step();
        bus.op_valid_i = 1'b0;
        chk("pre_rst_dosqrt", {31'd0, bus.doSqrt_o}, 32'd1);
        step();
        rst = 1'b0;
        #1;
        chk("mid_rst_dosqrt", {31'd0, bus.doSqrt_o}, 32'd0);
        chk("mid_rst_op_ready", {31'd0, bus.op_ready_o}, 32'd1);
        chk("mid_rst_res_valid", {31'd0, bus.res_valid_o}, 32'd0);
        bus.valid_i = 1'b1;
        bus.res_i = 16'h8000;
        step();
        rst = 1'b1;
        repeat (3) begin
            step();
            chk("post_rst_idle", {30'd0, bus.op_ready_o, bus.res_valid_o}, 32'd2);
        end
        bus.valid_i = 1'b0;
        run_op(16'h4080, 1'b0, 1'b0, 16'h8000, 1, {8'h80, 1'b0, 1'b0}, 16'h4000, 1'b0);
        repeat (3) step();
        chk("scoreboard_empty", iss_q.size() + res_exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
        $finish;
    end
endmodule
